pcs_tx_multilane: RTL and testbench
===================================

// Module: pcs_tx_multilane
// PURPOSE
//  Parametrised multi-lane 64b/66b TX PCS core, the successor to the fixed 4-lane 40G TX path.
//  Takes NUM_LANES pre-encoded 64-bit blocks per core_clk from the MAC and scrambles them (x^58+x^39+1).
//  Inserts per-lane alignment markers every AM_PERIOD cycles, with per-lane BIP3/BIP7 parity.
//  Fills idle cycles with scrambled idle control blocks and presents 66-bit blocks per lane to the TX gearboxes.
// PARAMETERS
//  NUM_LANES  4                 lanes per cycle (4 = 40GBASE-R, 20 = 100G PCS lanes)
//  AM_PERIOD  16384             core_clk cycles between marker cycles, marker cycle included; legal range 2..2^20
//  AM_ENC     {4{24'h0}}        NUM_LANES*24 bits; lane i marker bytes {M2,M1,M0} = AM_ENC[i*24+:24]
// PORTS
//  core_clk       in   1              core clock
//  core_reset     in   1              asynchronous, active-high reset
//  tx_data_ready  out  1              block accepted this cycle when high with tx_data_valid
//  tx_data_valid  in   1              tx_data/tx_ctrl valid
//  tx_data        in   NUM_LANES*64   lane i block payload = tx_data[i*64+:64], bit 0 first on wire
//  tx_ctrl        in   NUM_LANES      lane i: 1 = control block (sync 2'b01), 0 = data block (sync 2'b10)
//  tx_lane        out  NUM_LANES*66   lane i = {payload[63:0], sync[1:0]}, to tx_async_gearbox
//  tx_lane_valid  out  1              tx_lane holds a valid block
//  am_insert      out  1              tx_lane holds alignment markers this cycle
// BEHAVIOUR
//  Reset: state S_INIT; tx_lane=0, tx_lane_valid=0, tx_data_ready=0, am_insert=0.
//  Reset: scrambler state = 58'h3FF_FFFF_FFFF_FFFF, BIP accumulators=0, period counter=0.
//  All outputs are registered; 1-cycle latency from accepted input to tx_lane.
//  FSM S_INIT -> S_AM (unconditional, first cycle out of reset).
//  FSM S_AM -> S_RUN (unconditional). Emits marker cycle; the first output after reset is a marker.
//  FSM S_RUN -> S_AM when period counter == AM_PERIOD-2; otherwise stay in S_RUN.
//  Period counter: cleared in S_AM; +1 per S_RUN cycle, so exactly AM_PERIOD-1 non-marker cycles between markers.
//  tx_data_ready = (state==S_RUN), registered: it is 0 in the cycle of S_AM and 0 in S_INIT.
//  Handshake: MAC holds data while ready low; data offered while ready low is not consumed.
//  S_RUN, valid&ready: lane i sync = tx_ctrl[i] ? 2'b01 : 2'b10; payload scrambled.
//  S_RUN, !valid: every lane = scrambled idle block (payload {56'h0, 8'h1E}), sync 2'b01.
//  Scrambler: self-synchronous serial over lane0 bits 0..63, then lane1, .., lane N-1 (one stream per cycle).
//  Scrambler: sync bits are never scrambled; state does not advance in S_AM or S_INIT.
//  Marker, lane i: sync 2'b01; payload bytes 0..7 = {M0,M1,M2,BIP3,~M0,~M1,~M2,BIP7}, byte 0 in bits 7:0.
//  Marker: not scrambled; BIP7 = ~BIP3.
//  BIP3 lane i: bit k = XOR of all 66-bit tx_lane[i] bits j (j mod 8 == k) over every non-marker block since the previous marker.
//  BIP: sync bits j=0,1 are included.
//  BIP accumulator: cleared in the marker cycle. Each lane has its own accumulator.
//  tx_lane_valid = 1 in every cycle after S_INIT; am_insert = 1 exactly in S_AM cycles.
//  Boundary: valid rising in the cycle ready falls is not accepted; the same word is accepted on the next S_RUN cycle.
//  Boundary: AM_PERIOD=2 alternates S_AM/S_RUN.
//  Boundary: reset mid-stream returns to S_INIT immediately. The in-flight output is dropped; the scrambler reseeds.
// TESTING
//  T1 reset release, NUM_LANES=4, AM_ENC lane0=24'h4D_69_90, valid=0:
//     cycle1 = marker, lane0 payload bytes 90,69,4D,00,6F,96,B2,FF; am_insert=1.
//     Following cycles: scrambled idle (sync 01); BIP3 of the next marker matches the model.
//  T2 AM_PERIOD=4, valid held 1 with an incrementing pattern:
//     tx_data_ready low 1 cycle in every 4; no word lost or duplicated.
//     Descrambled lanes equal the input in order.
//  T3 tx_ctrl=4'b0101, data 64'h0123_4567_89AB_CDEF on all lanes:
//     lanes 0,2 sync 01, lanes 1,3 sync 10; payloads match a bit-serial x^58 model after 1 cycle.
//  T4 single-bit flip injected into model-expected lane2 block:
//     the model's BIP3 at the next marker differs from DUT tx_lane BIP3 in exactly the flipped bit position mod 8.
//  T5 core_reset pulsed mid-burst (counter=2, AM_PERIOD=8):
//     outputs are 0 during reset; first post-reset cycle is a marker with BIP3=8'h00, BIP7=8'hFF.
//  T6 NUM_LANES=20, random valid/ctrl for 10^5 cycles:
//     scoreboard of accepted blocks vs descrambled output; marker spacing is exactly AM_PERIOD.

Source files
------------

// File: rtl/pcs_tx_multilane.sv
// pcs_tx_multilane: parametrised multi-lane 64b/66b TX PCS core.
// Scrambles NUM_LANES MAC blocks per cycle as one serial x^58+x^39+1 stream.
// Emits an alignment-marker cycle every AM_PERIOD cycles, with per-lane BIP3/BIP7.
// Fills cycles without MAC data with scrambled idle control blocks.
module pcs_tx_multilane #(
  parameter int                      NUM_LANES = 4,
  parameter int                      AM_PERIOD = 16384,
  parameter logic [NUM_LANES*24-1:0] AM_ENC    = '0
) (
  input  logic                    core_clk,
  input  logic                    core_reset,
  output logic                    tx_data_ready,
  input  logic                    tx_data_valid,
  input  logic [NUM_LANES*64-1:0] tx_data,
  input  logic [NUM_LANES-1:0]    tx_ctrl,
  output logic [NUM_LANES*66-1:0] tx_lane,
  output logic                    tx_lane_valid,
  output logic                    am_insert
);

  localparam int          W        = NUM_LANES * 64;
  localparam int          CW       = $clog2(AM_PERIOD);
  localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;
  localparam logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {S_INIT = 2'd0, S_AM = 2'd1, S_RUN = 2'd2} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [CW-1:0]               r_cnt;
  logic [57:0]                 r_scr;
  logic [NUM_LANES-1:0][7:0]   r_bip;
  logic [W-1:0]                w_plain;
  logic [W-1:0]                w_scr_data;
  logic [57:0]                 w_scr_next;
  logic [NUM_LANES*66-1:0]     w_run_lane;
  logic [NUM_LANES*66-1:0]     w_am_lane;

  // Serial self-synchronous scrambler run over the whole cycle's payload stream.
  function automatic logic [W+57:0] scramble(input logic [W-1:0] d, input logic [57:0] s);
    logic [57:0] st;
    logic [W-1:0] q;
    logic b;
    st = s;
    q  = '0;
    for (int k = 0; k < W; k++) begin
      b    = d[k] ^ st[38] ^ st[57];
      q[k] = b;
      st   = {st[56:0], b};
    end
    return {st, q};
  endfunction

  // Interleaved parity of one 66-bit block: bit k covers block bits j with j mod 8 == k.
  function automatic logic [7:0] bip_fold(input logic [65:0] blk);
    logic [7:0] f;
    f = 8'h00;
    for (int k = 0; k < 8; k++) begin
      for (int m = 0; m < 9; m++) begin
        if (8 * m + k < 66) begin
          f[k] = f[k] ^ blk[8*m+k];
        end
      end
    end
    return f;
  endfunction

  // State register.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) r_state <= S_INIT;
    else            r_state <= w_next;
  end

  // Next-state: one marker cycle, then AM_PERIOD-1 run cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: w_next = S_AM;
      S_AM:   w_next = S_RUN;
      S_RUN: begin
        if (r_cnt == CW'(AM_PERIOD - 2)) w_next = S_AM;
        else                              w_next = S_RUN;
      end
      default: w_next = S_INIT;
    endcase
  end

  // Period counter: restarts on every marker cycle, counts run cycles.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset)            r_cnt <= '0;
    else if (r_state == S_AM)  r_cnt <= '0;
    else if (r_state == S_RUN) r_cnt <= r_cnt + CW'(1);
    else                       r_cnt <= r_cnt;
  end

  // Payload to scramble: accepted MAC blocks, or idle control blocks on every lane.
  always_comb begin
    w_plain = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (tx_data_valid) w_plain[i*64 +: 64] = tx_data[i*64 +: 64];
      else               w_plain[i*64 +: 64] = IDLE_BLK;
    end
  end

  assign {w_scr_next, w_scr_data} = scramble(w_plain, r_scr);

  // Assemble the run-cycle blocks and the marker blocks for every lane.
  always_comb begin
    w_run_lane = '0;
    w_am_lane  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_run_lane[i*66 +: 66] = {w_scr_data[i*64 +: 64],
                                (tx_data_valid && !tx_ctrl[i]) ? 2'b10 : 2'b01};
      w_am_lane[i*66 +: 66]  = {~r_bip[i], ~AM_ENC[i*24+16 +: 8], ~AM_ENC[i*24+8 +: 8],
                                ~AM_ENC[i*24 +: 8], r_bip[i], AM_ENC[i*24+16 +: 8],
                                AM_ENC[i*24+8 +: 8], AM_ENC[i*24 +: 8], 2'b01};
    end
  end

  // Scrambler state advances only across run cycles; markers pass through unscrambled.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset)            r_scr <= SCR_SEED;
    else if (r_state == S_RUN) r_scr <= w_scr_next;
    else                       r_scr <= r_scr;
  end

  // Per-lane BIP accumulation over transmitted run blocks, cleared by each marker.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      r_bip <= '0;
    end else if (r_state == S_AM) begin
      r_bip <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_bip[i] <= r_bip[i] ^ bip_fold(w_run_lane[i*66 +: 66]);
      end
    end else begin
      r_bip <= r_bip;
    end
  end

  // Registered outputs: one cycle after the state that produced them.
  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      tx_lane       <= '0;
      tx_lane_valid <= 1'b0;
      am_insert     <= 1'b0;
      tx_data_ready <= 1'b0;
    end else begin
      tx_data_ready <= (w_next == S_RUN);
      case (r_state)
        S_AM: begin
          tx_lane       <= w_am_lane;
          tx_lane_valid <= 1'b1;
          am_insert     <= 1'b1;
        end
        S_RUN: begin
          tx_lane       <= w_run_lane;
          tx_lane_valid <= 1'b1;
          am_insert     <= 1'b0;
        end
        default: begin
          tx_lane       <= '0;
          tx_lane_valid <= 1'b0;
          am_insert     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_tx_multilane.sv
// tb_pcs_tx_multilane: randomized bench for pcs_tx_multilane with a cycle-level
// behavioural model (marker schedule by arithmetic, bit-serial scrambler, BIP by bit loops).
module tb_pcs_tx_multilane;

  localparam int NL = 4;
  localparam int AP = 4;
  localparam logic [NL*24-1:0] ENC = {24'hA2_79_3D, 24'hC5_65_9B, 24'hF0_C4_E6, 24'h4D_69_90};

  logic              core_clk = 1'b0;
  logic              core_reset = 1'b1;
  logic              tx_data_ready;
  logic              tx_data_valid;
  logic [NL*64-1:0]  tx_data;
  logic [NL-1:0]     tx_ctrl;
  logic [NL*66-1:0]  tx_lane;
  logic              tx_lane_valid;
  logic              am_insert;

  always #5 core_clk = ~core_clk;

  pcs_tx_multilane #(.NUM_LANES(NL), .AM_PERIOD(AP), .AM_ENC(ENC)) dut (
    .core_clk      (core_clk),
    .core_reset    (core_reset),
    .tx_data_ready (tx_data_ready),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .tx_ctrl       (tx_ctrl),
    .tx_lane       (tx_lane),
    .tx_lane_valid (tx_lane_valid),
    .am_insert     (am_insert)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int          cyc;
  logic [57:0] m_scr;
  logic [7:0]  m_bip [NL];
  logic        m_accepted;
  logic [65:0] exp_lane [NL];
  logic [63:0] exp_plain [NL];
  logic        exp_valid, exp_am, exp_ready;
  int          exp_kind;      // 0 = nothing sent, 1 = marker, 2 = run block
  logic        chk_en = 1'b0;
  logic [31:0] seq = 32'd0;
  // bit-flip shadow accumulator for lane 2
  logic        flip_req, flip_seen, t4_pend;
  int          flip_j;
  logic [7:0]  sh_bip, sh_final;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int phase(input int c);
    if (c == 0) return 0;
    if ((c - 1) % AP == 0) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_scr = 58'h3FF_FFFF_FFFF_FFFF;
    for (int i = 0; i < NL; i++) begin
      m_bip[i] = 8'h00;
      exp_lane[i] = '0;
      exp_plain[i] = '0;
    end
    m_accepted = 1'b0;
    exp_valid = 1'b0; exp_am = 1'b0; exp_ready = 1'b0; exp_kind = 0;
    flip_req = 1'b0; flip_seen = 1'b0; t4_pend = 1'b0; sh_bip = 8'h00; sh_final = 8'h00;
  endtask

  // Advance the model across one clock edge, using the inputs present at that edge.
  task automatic model_update();
    int ph;
    logic [63:0] plain, pay;
    logic [65:0] blk;
    logic sb;
    logic [7:0] mb [8];
    logic [NL*24-1:0] enc_v;
    ph = phase(cyc);
    m_accepted = 1'b0;
    enc_v = ENC;
    if (ph == 1) begin
      for (int i = 0; i < NL; i++) begin
        mb[0] = enc_v[i*24 +: 8];
        mb[1] = enc_v[i*24+8 +: 8];
        mb[2] = enc_v[i*24+16 +: 8];
        mb[3] = m_bip[i];
        for (int n = 0; n < 4; n++) mb[n+4] = ~mb[n];
        for (int n = 0; n < 8; n++) pay[n*8 +: 8] = mb[n];
        exp_lane[i] = {pay, 2'b01};
        m_bip[i] = 8'h00;
      end
      if (flip_seen) begin
        sh_final = sh_bip;
        t4_pend = 1'b1;
        flip_seen = 1'b0;
      end
      sh_bip = 8'h00;
      exp_valid = 1'b1; exp_am = 1'b1; exp_kind = 1;
    end else if (ph == 2) begin
      for (int i = 0; i < NL; i++) begin
        plain = tx_data_valid ? tx_data[i*64 +: 64] : 64'h0000_0000_0000_001E;
        for (int b = 0; b < 64; b++) begin
          sb = plain[b] ^ m_scr[38] ^ m_scr[57];
          pay[b] = sb;
          m_scr = {m_scr[56:0], sb};
        end
        exp_lane[i] = {pay, (tx_data_valid && !tx_ctrl[i]) ? 2'b10 : 2'b01};
        exp_plain[i] = plain;
        for (int j = 0; j < 66; j++) m_bip[i][j%8] = m_bip[i][j%8] ^ exp_lane[i][j];
        if (i == 2) begin
          blk = exp_lane[2];
          if (flip_req) blk[flip_j] = ~blk[flip_j];
          for (int j = 0; j < 66; j++) sh_bip[j%8] = sh_bip[j%8] ^ blk[j];
        end
      end
      if (flip_req) begin
        flip_req = 1'b0;
        flip_seen = 1'b1;
      end
      m_accepted = tx_data_valid;
      exp_valid = 1'b1; exp_am = 1'b0; exp_kind = 2;
    end
    cyc++;
    exp_ready = (phase(cyc) == 2);
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
    model_update();
    if (t4_pend) begin
      chk("t4_bip_flip", 8'(tx_lane[2*66+26 +: 8] ^ sh_final), 8'(8'd1 << (flip_j % 8)));
      t4_pend = 1'b0;
    end
  endtask

  // MAC side: a new word only after the previous one was taken (or none was offered).
  task automatic drive(input int pv, input bit incr);
    if (m_accepted || !tx_data_valid) begin
      tx_data_valid = ($urandom_range(99) < 32'(pv));
      for (int i = 0; i < NL; i++)
        tx_data[i*64 +: 64] = incr ? {seq, 32'(i)} : {$urandom, $urandom};
      tx_ctrl = NL'($urandom);
      seq = seq + 32'd1;
    end
  endtask

  // Compare process: every cycle outputs against the model, plus descrambled payload
  // and marker spacing measured on the DUT output.
  logic [57:0] ds;
  logic [63:0] dplain;
  logic        sbit;
  int          since_am;
  bit          seen_am;
  initial begin
    ds = 58'h3FF_FFFF_FFFF_FFFF;
    since_am = 0;
    seen_am = 0;
    forever begin
      @(negedge core_clk);
      if (chk_en) begin
        chk("tx_data_ready", tx_data_ready, exp_ready);
        chk("tx_lane_valid", tx_lane_valid, exp_valid);
        chk("am_insert", am_insert, exp_am);
        for (int i = 0; i < NL; i++)
          chk($sformatf("tx_lane%0d", i), tx_lane[i*66 +: 66], exp_lane[i]);
        if (exp_kind == 2) begin
          for (int i = 0; i < NL; i++) begin
            for (int b = 0; b < 64; b++) begin
              sbit = tx_lane[i*66+2+b];
              dplain[b] = sbit ^ ds[38] ^ ds[57];
              ds = {ds[56:0], sbit};
            end
            chk($sformatf("descrambled%0d", i), dplain, exp_plain[i]);
          end
        end else if (exp_kind == 0) begin
          ds = 58'h3FF_FFFF_FFFF_FFFF;
        end
        if (exp_kind == 0) begin
          seen_am = 0;
          since_am = 0;
        end else begin
          since_am++;
          if (am_insert) begin
            if (seen_am) chk("am_spacing", since_am, AP);
            seen_am = 1;
            since_am = 0;
          end
        end
      end
    end
  end

  initial begin
    int g;
    tx_data_valid = 1'b0;
    tx_data = '0;
    tx_ctrl = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    core_reset = 1'b0;

    // T1: reset release, no MAC data
    step();
    step();
    chk("t1_marker_lane0", tx_lane[65:0], {64'hFFB2_966F_004D_6990, 2'b01});
    chk("t1_am_insert", am_insert, 1'b1);
    step();
    chk("t1_idle_lane0", tx_lane[65:0], {64'h7BFF_F080_0000_001E, 2'b01});
    repeat (10) step();

    // T2: valid held high with an incrementing pattern
    for (int c = 0; c < 24; c++) begin
      drive(100, 1'b1);
      step();
    end

    // T3: fixed data, mixed control/data lanes
    tx_data_valid = 1'b1;
    tx_ctrl = 4'b0101;
    tx_data = {NL{64'h0123_4567_89AB_CDEF}};
    g = 0;
    do begin
      step();
      g++;
    end while (!m_accepted && g < 2 * AP);
    chk("t3_accept_within_bound", m_accepted, 1'b1);
    chk("t3_sync", {tx_lane[3*66 +: 2], tx_lane[2*66 +: 2], tx_lane[66 +: 2], tx_lane[1:0]},
        8'b10_01_10_01);

    // T4 + random traffic with periodic bit flips in the shadow lane-2 BIP
    for (int c = 0; c < 1500; c++) begin
      if (c % 37 == 5 && !flip_seen) begin
        flip_req = 1'b1;
        flip_j = int'($urandom_range(65));
      end
      drive(60, 1'b0);
      step();
    end

    // T5: reset mid-burst at period counter 2
    tx_data_valid = 1'b1;
    g = 0;
    while (!(phase(cyc) == 2 && (cyc - 1) % AP == 3) && g < 2 * AP) begin
      step();
      g++;
    end
    chk("t5_reached_count2", phase(cyc) == 2 && (cyc - 1) % AP == 3, 1'b1);
    core_reset = 1'b1;
    model_reset();
    repeat (2) begin
      @(posedge core_clk);
      #1;
    end
    core_reset = 1'b0;
    step();
    step();
    chk("t5_am_insert", am_insert, 1'b1);
    chk("t5_bip3_lane0", tx_lane[26 +: 8], 8'h00);
    chk("t5_bip7_lane0", tx_lane[58 +: 8], 8'hFF);

    // T6: more random traffic after the reset
    for (int c = 0; c < 1500; c++) begin
      if (c % 41 == 7 && !flip_seen) begin
        flip_req = 1'b1;
        flip_j = int'($urandom_range(65));
      end
      drive(50, 1'b0);
      step();
    end

    @(posedge core_clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
